// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared encodings and step-count helpers for the calculator core
//
// Purpose : op codes, FSM state codes, sequencer mode codes and the
//           per-operation iteration counts used by calc_core and
//           calc_seq_datapath.
// Ports   : none (package).
// Config  : CALC_FAST_MUL_EN - when defined, mul retires two multiplier
//           bits per step, so it needs half as many steps (rounded up).

package calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } seq_mode_e;

   // Number of iterations the shared datapath spends on a multiply.
   function automatic int mul_steps(input int width);
`ifdef CALC_FAST_MUL_EN
      return (width + 1) / 2;
`else
      return width;
`endif
   endfunction

   // Restoring division always retires one quotient bit per step.
   function automatic int div_steps(input int width);
      return width;
   endfunction

endpackage

// File: rtl/calc_seq_datapath.sv
// rtl/calc_seq_datapath.sv - iterative shift-add multiplier / restoring divider
//
// Purpose : one set of shift registers and one adder/subtractor serving
//           both mul (LSB-first shift-add) and div (MSB-first restoring).
// Ports   : clk, rst        clock, synchronous active-high reset
//           mode            MODE_MUL / MODE_DIV, captured on load
//           load            capture a, b and clear the step counter
//           step            perform one iteration
//           a, b            operands (a*b, or a/b)
//           result          value after the current step: product, or
//                           {remainder, quotient}; valid when last_step=1
//           last_step       this step is the final iteration
// Config  : CALC_FAST_MUL_EN - mul consumes two multiplier bits per step.

module calc_seq_datapath
   import calc_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  seq_mode_e          mode,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] result,
   output logic               last_step
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] MUL_LAST = CW'(mul_steps(WIDTH) - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(div_steps(WIDTH) - 1);

   // hi  : product accumulator (mul) / partial remainder (div)
   // lo  : multiplier shifted right (mul) / dividend shifting into quotient (div)
   // opnd: multiplicand shifted left (mul) / divisor (div)
   logic [2*WIDTH-1:0] hi, hi_nx;
   logic [WIDTH-1:0]   lo, lo_nx;
   logic [2*WIDTH-1:0] opnd, opnd_nx;
   logic [CW-1:0]      cnt;
   seq_mode_e          mode_q;

   logic [WIDTH:0]     r_shift;
   logic [WIDTH:0]     divisor;
   logic [WIDTH:0]     rem_full;
   logic               ge;
   logic [2*WIDTH-1:0] pp0;
   logic [2*WIDTH-1:0] pp1;

   always_comb begin
      pp0      = '0;
      pp1      = '0;
      r_shift  = '0;
      divisor  = '0;
      rem_full = '0;
      ge       = 1'b0;
      hi_nx    = hi;
      lo_nx    = lo;
      opnd_nx  = opnd;
      if (mode_q == MODE_MUL) begin
         pp0 = lo[0] ? opnd : '0;
`ifdef CALC_FAST_MUL_EN
         // Second partial product chained onto the first in the same cycle.
         pp1     = lo[1] ? (opnd << 1) : '0;
         opnd_nx = opnd << 2;
         lo_nx   = lo >> 2;
`else
         opnd_nx = opnd << 1;
         lo_nx   = lo >> 1;
`endif
         hi_nx = hi + pp0 + pp1;
      end else begin
         // Bring down the next dividend bit, then subtract if it fits.
         r_shift  = {hi[WIDTH-1:0], lo[WIDTH-1]};
         divisor  = {1'b0, opnd[WIDTH-1:0]};
         ge       = (r_shift >= divisor);
         rem_full = ge ? (r_shift - divisor) : r_shift;
         hi_nx    = {{(WIDTH-1){1'b0}}, rem_full};
         lo_nx    = {lo[WIDTH-2:0], ge};
      end
   end

   assign result = (mode_q == MODE_DIV) ? {hi_nx[WIDTH-1:0], lo_nx} : hi_nx;

   assign last_step = step && (cnt == ((mode_q == MODE_DIV) ? DIV_LAST : MUL_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         hi     <= '0;
         lo     <= '0;
         opnd   <= '0;
         cnt    <= '0;
         mode_q <= MODE_MUL;
      end else if (load) begin
         hi     <= '0;
         mode_q <= mode;
         cnt    <= '0;
         if (mode == MODE_DIV) begin
            lo   <= a;
            opnd <= {{WIDTH{1'b0}}, b};
         end else begin
            lo   <= b;
            opnd <= {{WIDTH{1'b0}}, a};
         end
      end else if (step) begin
         hi   <= hi_nx;
         lo   <= lo_nx;
         opnd <= opnd_nx;
         // Counter parks on the final step rather than wrapping.
         if (!last_step) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/calc_core.sv
// rtl/calc_core.sv - unsigned four-function calculator core with start/busy/done
//
// Purpose : add and sub resolve in one cycle; mul and div run on the shared
//           iterative datapath. Operands are captured at the accepted start.
// Ports   : clk, rst   clock, synchronous active-high reset
//           a, b       WIDTH-bit unsigned operands
//           op         00 add, 01 sub, 10 mul, 11 div
//           start      request; only accepted while idle
//           busy       operation in progress (cycle after accept .. done cycle)
//           done       one-cycle pulse, out/err valid from this cycle
//           out        2*WIDTH-bit result, held until the next done
//           err        add carry, sub negative, or divide by zero
// Config  : CALC_FAST_MUL_EN - two multiplier bits per mul step.

module calc_core
   import calc_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [1:0]         op,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] out,
   output logic               err
);

   state_e             state;
   op_e                op_sel;
   logic               accept;
   logic               b_zero;
   logic [WIDTH:0]     sum;
   logic               dp_load;
   logic               dp_step;
   seq_mode_e          dp_mode;
   logic [2*WIDTH-1:0] dp_result;
   logic               dp_last;

   assign op_sel  = op_e'(op);
   assign accept  = (state == ST_IDLE) && start;
   assign b_zero  = (b == '0);
   assign sum     = {1'b0, a} + {1'b0, b};
   assign dp_mode = (op_sel == OP_DIV) ? MODE_DIV : MODE_MUL;
   assign dp_load = accept && ((op_sel == OP_MUL) || ((op_sel == OP_DIV) && !b_zero));
   assign dp_step = (state == ST_MUL) || (state == ST_DIV);

   calc_seq_datapath #(
      .WIDTH (WIDTH)
   ) u_seq (
      .clk       (clk),
      .rst       (rst),
      .mode      (dp_mode),
      .load      (dp_load),
      .step      (dp_step),
      .a         (a),
      .b         (b),
      .result    (dp_result),
      .last_step (dp_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         out   <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (accept) begin
                  busy <= 1'b1;
                  case (op_sel)
                     OP_ADD: begin
                        out   <= {{(WIDTH-1){1'b0}}, sum};
                        err   <= sum[WIDTH];
                        done  <= 1'b1;
                        state <= ST_DONE;
                     end
                     OP_SUB: begin
                        // Negative differences report magnitude with err set.
                        if (a >= b) begin
                           out <= {{WIDTH{1'b0}}, a - b};
                           err <= 1'b0;
                        end else begin
                           out <= {{WIDTH{1'b0}}, b - a};
                           err <= 1'b1;
                        end
                        done  <= 1'b1;
                        state <= ST_DONE;
                     end
                     OP_MUL: begin
                        state <= ST_MUL;
                     end
                     default: begin
                        if (b_zero) begin
                           out   <= '0;
                           err   <= 1'b1;
                           done  <= 1'b1;
                           state <= ST_DONE;
                        end else begin
                           state <= ST_DIV;
                        end
                     end
                  endcase
               end
            end
            ST_MUL, ST_DIV: begin
               // Result is taken from the datapath's post-step value so it
               // lands on the same edge that enters DONE.
               if (dp_last) begin
                  out   <= dp_result;
                  err   <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_core.sv
// tb/tb_calc_core.sv - self-checking scoreboard bench for calc_core

module tb_calc_core;

   localparam int W = 6;

   typedef struct {
      logic [2*W-1:0] out;
      logic           err;
      int             lat;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [1:0]     op;
   logic           start;
   logic           busy;
   logic           done;
   logic [2*W-1:0] out;
   logic           err;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   calc_core #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .op    (op),
      .start (start),
      .busy  (busy),
      .done  (done),
      .out   (out),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int mul_lat();
`ifdef CALC_FAST_MUL_EN
      return (W + 1) / 2 + 1;
`else
      return W + 1;
`endif
   endfunction

   // Reference model built from plain arithmetic operators.
   function automatic exp_t model(input int ta, input int tb, input logic [1:0] top);
      exp_t e;
      int   s;
      case (top)
         2'b00: begin
            s = ta + tb;
            e.out = (2*W)'(s);
            e.err = (s >= (1 << W));
            e.lat = 1;
         end
         2'b01: begin
            e.out = (2*W)'((ta >= tb) ? ta - tb : tb - ta);
            e.err = (ta < tb);
            e.lat = 1;
         end
         2'b10: begin
            e.out = (2*W)'(ta * tb);
            e.err = 1'b0;
            e.lat = mul_lat();
         end
         default: begin
            if (tb == 0) begin
               e.out = '0;
               e.err = 1'b1;
               e.lat = 1;
            end else begin
               e.out = (2*W)'(((ta % tb) << W) + (ta / tb));
               e.err = 1'b0;
               e.lat = W + 1;
            end
         end
      endcase
      return e;
   endfunction

   function automatic exp_t mk(input int o, input logic e, input int l);
      exp_t x;
      x.out = (2*W)'(o);
      x.err = e;
      x.lat = l;
      return x;
   endfunction

   // Drive one operation, push its expectation, and compare when done fires.
   // disturb: toggle start/a/b/op while busy, and hold start high in DONE.
   task automatic run_op(input string tag, input int ta, input int tb, input logic [1:0] top,
                         input exp_t e, input bit disturb);
      exp_t got;
      int   lat;
      bit   seen;
      sb.push_back(e);
      @(negedge clk);
      a     = W'(ta);
      b     = W'(tb);
      op    = top;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      seen  = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      while (!seen && lat < 100) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (disturb) begin
               start = 1'($urandom_range(0, 1));
               a     = W'($urandom);
               b     = W'($urandom);
               op    = 2'($urandom);
            end
            @(negedge clk);
            lat++;
         end
      end
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      got = sb.pop_front();
      chk({tag, "_out"}, 64'(out), 64'(got.out));
      chk({tag, "_err"}, 64'(err), 64'(got.err));
      chk({tag, "_lat"}, 64'(lat), 64'(got.lat));
      // Start presented during the DONE cycle must be ignored.
      start = disturb;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_done_width"}, 64'(done), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      chk({tag, "_hold"}, 64'(out), 64'(got.out));
   endtask

   initial begin
      int ra;
      int rb;
      logic [1:0] rop;
      rst   = 1'b1;
      a     = '0;
      b     = '0;
      op    = 2'b00;
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      rst = 1'b0;

      run_op("add_carry", 63, 1, 2'b00, mk(64, 1'b1, 1), 1'b0);
      run_op("add_plain", 20, 22, 2'b00, mk(42, 1'b0, 1), 1'b0);
      run_op("sub_neg", 5, 9, 2'b01, mk(4, 1'b1, 1), 1'b0);
      run_op("sub_pos", 9, 5, 2'b01, mk(4, 1'b0, 1), 1'b0);
      run_op("mul_max", 63, 63, 2'b10, mk(3969, 1'b0, mul_lat()), 1'b0);
      run_op("mul_zero", 0, 37, 2'b10, mk(0, 1'b0, mul_lat()), 1'b0);
      run_op("div_45_7", 45, 7, 2'b11, mk(198, 1'b0, W + 1), 1'b0);
      run_op("div_zero", 5, 0, 2'b11, mk(0, 1'b1, 1), 1'b0);
      run_op("mul_disturb", 45, 51, 2'b10, mk(2295, 1'b0, mul_lat()), 1'b1);
      run_op("div_disturb", 62, 9, 2'b11, mk((8 << W) + 6, 1'b0, W + 1), 1'b1);

      // Leave a nonzero result, then reset in the middle of a divide.
      run_op("mul_pre_rst", 7, 9, 2'b10, mk(63, 1'b0, mul_lat()), 1'b0);
      @(negedge clk);
      a     = W'(45);
      b     = W'(7);
      op    = 2'b11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_out", 64'(out), 64'd0);
      chk("midrst_err", 64'(err), 64'd0);
      run_op("div_after_rst", 45, 7, 2'b11, mk(198, 1'b0, W + 1), 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra  = int'($urandom_range(0, (1 << W) - 1));
         rb  = int'($urandom_range(0, (1 << W) - 1));
         if (i % 8 == 3) rb = 0;
         rop = 2'($urandom);
         run_op("rand", ra, rb, rop, model(ra, rb, rop), 1'(i % 5 == 0));
      end

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
